// File: rtl/fpu_hs_pkg.sv
// Shared definitions for the strobe/acknowledge FPU initiator.
package fpu_hs_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_A   = 3'd1,
    SEND_B   = 3'd2,
    WAIT_Z   = 3'd3,
    HOLD_RES = 3'd4
  } state_t;

  // Result reported for a transaction the watchdog had to abort.
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // One FIFO entry holds {operand A, operand B}.
  localparam int PAIR_W = 64;

endpackage

// File: rtl/fpu_operand_fifo.sv
// Small synchronous FIFO holding operand pairs waiting for the FPU.
module fpu_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd];

  // Storage array; no reset so it maps onto plain RAM/regs.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_stream_master.sv
// Initiator for a stb/ack FPU: queues operand pairs, sends A then B,
// collects Z and offers it on a valid/ready port, with a stall watchdog.
module fpu_stream_master
  import fpu_hs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] fpu_a,
  output logic        fpu_a_stb,
  input  logic        fpu_a_ack,
  output logic [31:0] fpu_b,
  output logic        fpu_b_stb,
  input  logic        fpu_b_ack,
  input  logic [31:0] fpu_z,
  input  logic        fpu_z_stb,
  output logic        fpu_z_ack,
  output logic [31:0] res_z,
  output logic        res_timeout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_wdog;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_a_stb;
  logic               r_b_stb;
  logic               r_z_ack;
  logic [31:0]        r_res_z;
  logic               r_res_timeout;
  logic               r_res_valid;

  logic [PAIR_W-1:0]  w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_a_xfer;
  logic               w_b_xfer;
  logic               w_z_xfer;
  logic               w_fpu_state;
  logic               w_xfer_now;
  logic               w_abort;
  logic               w_state_change;

  assign w_push    = cmd_valid && !w_full;
  assign w_a_xfer  = r_a_stb && fpu_a_ack;
  assign w_b_xfer  = r_b_stb && fpu_b_ack;
  assign w_z_xfer  = r_z_ack && fpu_z_stb;
  assign w_fpu_state = (r_state == SEND_A) || (r_state == SEND_B) || (r_state == WAIT_Z);

  // The counter holds the number of edges already spent in the state, so the
  // edge that would make it TIMEOUT is the last one allowed: abort there.
  assign w_abort = (TIMEOUT != 0) && w_fpu_state && !w_xfer_now &&
                   (r_wdog == CNT_W'(TIMEOUT - 1));

  // The head is only popped once B is delivered, or when an abort leaves it unsent.
  assign w_pop = ((r_state == SEND_B) && w_b_xfer) ||
                 (w_abort && ((r_state == SEND_A) || (r_state == SEND_B)));

  // Transfer relevant to the current state, and whether the FSM moves this edge.
  always_comb begin
    w_xfer_now     = 1'b0;
    w_state_change = 1'b0;
    unique case (r_state)
      IDLE:     w_state_change = !w_empty;
      SEND_A:   w_xfer_now = w_a_xfer;
      SEND_B:   w_xfer_now = w_b_xfer;
      WAIT_Z:   w_xfer_now = w_z_xfer;
      HOLD_RES: w_state_change = res_ready;
      default:  w_state_change = 1'b1;
    endcase
    if (w_xfer_now || w_abort) w_state_change = 1'b1;
  end

  fpu_operand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_data  ({cmd_a, cmd_b}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Watchdog counts edges spent in the FPU-facing states, restarting on every move.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (w_state_change || !w_fpu_state) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Transaction FSM: one pair in flight, result held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_a_stb       <= 1'b0;
      r_b_stb       <= 1'b0;
      r_z_ack       <= 1'b0;
      r_res_z       <= '0;
      r_res_timeout <= 1'b0;
      r_res_valid   <= 1'b0;
    end else if (w_abort) begin
      r_a_stb       <= 1'b0;
      r_b_stb       <= 1'b0;
      r_z_ack       <= 1'b0;
      r_res_z       <= QNAN;
      r_res_timeout <= 1'b1;
      r_res_valid   <= 1'b1;
      r_state       <= HOLD_RES;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_a     <= w_head[63:32];
            r_b     <= w_head[31:0];
            r_a_stb <= 1'b1;
            r_state <= SEND_A;
          end
        end
        SEND_A: begin
          if (w_a_xfer) begin
            r_a_stb <= 1'b0;
            r_b_stb <= 1'b1;
            r_state <= SEND_B;
          end
        end
        SEND_B: begin
          if (w_b_xfer) begin
            r_b_stb <= 1'b0;
            r_z_ack <= 1'b1;
            r_state <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (w_z_xfer) begin
            r_res_z       <= fpu_z;
            r_z_ack       <= 1'b0;
            r_res_timeout <= 1'b0;
            r_res_valid   <= 1'b1;
            r_state       <= HOLD_RES;
          end
        end
        HOLD_RES: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = !w_full;
  assign fpu_a       = r_a;
  assign fpu_b       = r_b;
  assign fpu_a_stb   = r_a_stb;
  assign fpu_b_stb   = r_b_stb;
  assign fpu_z_ack   = r_z_ack;
  assign res_z       = r_res_z;
  assign res_timeout = r_res_timeout;
  assign res_valid   = r_res_valid;
  assign busy        = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_fpu_stream_master.sv
// Directed bench for fpu_stream_master with a behavioural stb/ack adder responder.
module tb_fpu_stream_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_a, cmd_b;
  logic        cmd_valid, cmd_ready;
  logic [31:0] fpu_a, fpu_b, fpu_z;
  logic        fpu_a_stb, fpu_a_ack, fpu_b_stb, fpu_b_ack;
  logic        fpu_z_stb, fpu_z_ack;
  logic [31:0] res_z;
  logic        res_timeout, res_valid, res_ready, busy;

  int vectors     = 0;
  int miscompares = 0;

  int aXfers = 0, bXfers = 0, zXfers = 0, resCount = 0, resTimeouts = 0;
  logic [31:0] lastA = '0, lastB = '0, zVal = '0;
  logic        zPending = 1'b0;
  bit          aAckEn, bAckEn, zEn;

  fpu_stream_master #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk (clk), .rst (rst),
    .cmd_a (cmd_a), .cmd_b (cmd_b), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .fpu_a (fpu_a), .fpu_a_stb (fpu_a_stb), .fpu_a_ack (fpu_a_ack),
    .fpu_b (fpu_b), .fpu_b_stb (fpu_b_stb), .fpu_b_ack (fpu_b_ack),
    .fpu_z (fpu_z), .fpu_z_stb (fpu_z_stb), .fpu_z_ack (fpu_z_ack),
    .res_z (res_z), .res_timeout (res_timeout), .res_valid (res_valid),
    .res_ready (res_ready), .busy (busy)
  );

  always #5 clk = ~clk;

  // Adder stand-in: sums for the operand pairs this bench uses, worked by hand.
  function automatic logic [31:0] addModel(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'hBF800000 && b == 32'h3F800000) return 32'h00000000;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    return a ^ b;
  endfunction

  assign fpu_a_ack = aAckEn;
  assign fpu_b_ack = bAckEn;
  assign fpu_z_stb = zPending && zEn;
  assign fpu_z     = zVal;

  // Responder and result monitor; the responder resets with the DUT.
  always @(posedge clk) begin
    if (!rst) begin
      zPending <= 1'b0;
    end else begin
      if (fpu_a_stb && fpu_a_ack) begin
        lastA  <= fpu_a;
        aXfers <= aXfers + 1;
      end
      if (fpu_b_stb && fpu_b_ack) begin
        lastB    <= fpu_b;
        bXfers   <= bXfers + 1;
        zVal     <= addModel(lastA, fpu_b);
        zPending <= 1'b1;
      end
      if (fpu_z_stb && fpu_z_ack) begin
        zXfers   <= zXfers + 1;
        zPending <= 1'b0;
      end
      if (res_valid && res_ready) begin
        resCount <= resCount + 1;
        if (res_timeout) resTimeouts <= resTimeouts + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0;
    aAckEn = 1'b1; bAckEn = 1'b1; zEn = 1'b1;
    tick();
    tick();
    vectors++;
    if ({fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid, res_timeout} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000",
               {fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid, res_timeout});
    end
    vectors++;
    if ({fpu_a, fpu_b, res_z} !== 96'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h %h %h want zeros", fpu_a, fpu_b, res_z);
    end
    vectors++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got busy=%b cmd_ready=%b want 0/1", busy, cmd_ready);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_add();
    int a0, b0;
    push(32'h3F800000, 32'h40000000);
    vectors++;
    if (fpu_a_stb !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL add_push_latency: got stb=%b busy=%b want 0/1", fpu_a_stb, busy);
    end
    tick();
    vectors++;
    if (fpu_a_stb !== 1'b1 || fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000) begin
      miscompares++;
      $display("[TB] FAIL add_a_strobe: got stb=%b a=%h b=%h want 1/3f800000/40000000",
               fpu_a_stb, fpu_a, fpu_b);
    end
    a0 = aXfers; b0 = bXfers;
    for (int i = 0; i < 20 && res_valid !== 1'b1; i++) tick();
    vectors++;
    if (res_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL add_res_wait: got res_valid=%b want 1", res_valid);
    end
    vectors++;
    if (res_z !== 32'h40400000 || res_timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_result: got %h/%b want 40400000/0", res_z, res_timeout);
    end
    vectors++;
    if (aXfers - a0 !== 1 || bXfers - b0 !== 1 || lastB !== 32'h40000000) begin
      miscompares++;
      $display("[TB] FAIL add_xfers: got a=%0d b=%0d lastB=%h want 1/1/40000000",
               aXfers - a0, bXfers - b0, lastB);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_accept: got valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_cancel();
    push(32'hBF800000, 32'h3F800000);
    for (int i = 0; i < 20 && res_valid !== 1'b1; i++) tick();
    vectors++;
    if (res_valid !== 1'b1 || res_z !== 32'h00000000 || res_timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cancel_result: got v=%b z=%h t=%b want 1/00000000/0",
               res_valid, res_z, res_timeout);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_full();
    int r0, t0;
    aAckEn = 1'b0;
    r0 = resCount; t0 = resTimeouts;
    for (int i = 0; i < 3; i++) push(32'h3F800000, 32'h40000000);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_after3: got cmd_ready=%b want 1", cmd_ready);
    end
    push(32'h3F800000, 32'h40000000);
    vectors++;
    if (cmd_ready !== 1'b0 || fpu_a_stb !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_after4: got cmd_ready=%b a_stb=%b want 0/1", cmd_ready, fpu_a_stb);
    end
    aAckEn = 1'b1;
    tick();
    vectors++;
    if (fpu_b_stb !== 1'b1 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_b_phase: got b_stb=%b cmd_ready=%b want 1/0", fpu_b_stb, cmd_ready);
    end
    tick();
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_pop: got cmd_ready=%b want 1", cmd_ready);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
    tick();
    res_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || resCount - r0 !== 4 || resTimeouts !== t0) begin
      miscompares++;
      $display("[TB] FAIL full_drain: got busy=%b results=%0d timeouts=%0d want 0/4/0",
               busy, resCount - r0, resTimeouts - t0);
    end
  endtask

  task automatic test_hold();
    int errs = 0;
    push(32'h3F800000, 32'h40000000);
    push(32'hBF800000, 32'h3F800000);
    for (int i = 0; i < 20 && res_valid !== 1'b1; i++) tick();
    vectors++;
    if (res_valid !== 1'b1 || res_z !== 32'h40400000) begin
      miscompares++;
      $display("[TB] FAIL hold_first: got v=%b z=%h want 1/40400000", res_valid, res_z);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_z !== 32'h40400000 || fpu_a_stb !== 1'b0) errs++;
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("[TB] FAIL hold_stable: got %0d unstable cycles want 0", errs);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || fpu_a_stb !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_release1: got v=%b a_stb=%b want 0/0", res_valid, fpu_a_stb);
    end
    tick();
    vectors++;
    if (fpu_a_stb !== 1'b1 || fpu_a !== 32'hBF800000) begin
      miscompares++;
      $display("[TB] FAIL hold_release2: got a_stb=%b a=%h want 1/bf800000", fpu_a_stb, fpu_a);
    end
    for (int i = 0; i < 20 && res_valid !== 1'b1; i++) tick();
    vectors++;
    if (res_valid !== 1'b1 || res_z !== 32'h00000000) begin
      miscompares++;
      $display("[TB] FAIL hold_second: got v=%b z=%h want 1/00000000", res_valid, res_z);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int errs = 0;
    zEn = 1'b0;
    push(32'h40000000, 32'h40000000);
    for (int i = 0; i < 20 && fpu_z_ack !== 1'b1; i++) tick();
    vectors++;
    if (fpu_z_ack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL to_enter_wait: got z_ack=%b want 1", fpu_z_ack);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (res_valid !== 1'b0 || fpu_z_ack !== 1'b1) errs++;
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("[TB] FAIL to_early: got %0d early-abort cycles want 0", errs);
    end
    tick();
    vectors++;
    if ({res_valid, res_timeout, fpu_z_ack} !== 3'b110 || res_z !== 32'h7FC00000) begin
      miscompares++;
      $display("[TB] FAIL to_abort: got v/t/ack=%b z=%h want 110/7fc00000",
               {res_valid, res_timeout, fpu_z_ack}, res_z);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL to_consumed: got busy=%b v=%b rdy=%b want 0/0/1", busy, res_valid, cmd_ready);
    end
    zEn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (fpu_z_ack !== 1'b0 || fpu_a_stb !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stray_z: got ack=%b a_stb=%b busy=%b want 0/0/0", fpu_z_ack, fpu_a_stb, busy);
    end
  endtask

  task automatic test_reset_mid();
    int a0, b0;
    aAckEn = 1'b1; bAckEn = 1'b0;
    push(32'h3F800000, 32'h40000000);
    push(32'hBF800000, 32'h3F800000);
    for (int i = 0; i < 10 && fpu_b_stb !== 1'b1; i++) tick();
    vectors++;
    if (fpu_b_stb !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_setup: got b_stb=%b want 1", fpu_b_stb);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vectors++;
    if ({fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid} !== 4'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_state: got ctrl=%b busy=%b rdy=%b want 0000/0/1",
               {fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid}, busy, cmd_ready);
    end
    a0 = aXfers; b0 = bXfers;
    bAckEn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (aXfers != a0 || bXfers != b0 || fpu_a_stb !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_quiet: got a=%0d b=%0d a_stb=%b want 0/0/0",
               aXfers - a0, bXfers - b0, fpu_a_stb);
    end
  endtask

  // Absolute bound so a wedged run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stopped");
  end

  initial begin
    test_reset();
    test_add();
    test_cancel();
    test_full();
    test_hold();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
